axi_reg_responder: RTL and testbench
====================================

AXI_REG_RESPONDER -- requirements
Module: axi_reg_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 'h40000000: byte address of register 0.
REQ-002 SHALL have parameter NUM_REGS, default 8: number of 64-bit registers, power of two, range 1..256.
REQ-003 SHALL have parameter req_t, default soc_pkg::s_req_t: AXI4 request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
REQ-004 SHALL have parameter resp_t, default soc_pkg::s_resp_t: AXI4 response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port srst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port req_i, input, req_t: AXI4 requests from the initiator.
REQ-008 SHALL have port resp_o, output, resp_t: AXI4 responses to the initiator; all fields not named below SHALL be driven 0.

Function
REQ-009 Write path FSM states: W_IDLE, W_DATA, W_RESP. Read path FSM states: R_IDLE, R_DATA. The two paths SHALL run independently and concurrently.
REQ-010 W_IDLE: aw_ready=1, w_ready=0. On AW handshake, latch id, addr, len, size; go to W_DATA.
REQ-011 W_DATA: aw_ready=0, w_ready=1. Each W handshake decrements the beat counter, initialised to len. A handshake with counter 0 goes to W_RESP.
REQ-012 W_RESP: b_valid=1, b.id = latched id, b.resp per REQ-016. On b_ready, go to W_IDLE. No AW is accepted before that.
REQ-013 Write commit: register bytes with strb[k]=1 SHALL update on the W handshake edge, only for an OKAY transaction. B SHALL appear the cycle after the final W handshake, earliest.
REQ-014 R_IDLE: ar_ready=1, r_valid=0. On AR handshake, latch id, addr, len, size; snapshot the addressed register into the r.data register on the same edge; go to R_DATA.
REQ-015 R_DATA: r_valid=1, r.id = latched id, r.resp per REQ-016, r.last=1 when the beat counter is 0. On r_ready, decrement the counter. On the last beat, go to R_IDLE.
- First r_valid SHALL be 1 cycle after the AR handshake.
REQ-016 Response code, evaluated on the latched address phase, first match wins:
- addr < BASE_ADDR or addr >= BASE_ADDR + 8*NUM_REGS -> DECERR (2'b11).
- addr[2:0] != 0, size != 3, or len != 0 -> SLVERR (2'b10).
- Otherwise OKAY (2'b00).
REQ-017 Register index SHALL be (addr - BASE_ADDR) >> 3, truncated to log2(NUM_REGS) bits.
REQ-018 Errored writes SHALL consume all len+1 W beats and modify no register.
REQ-019 Errored reads SHALL return len+1 beats with r.data = 0, each carrying the error resp.
REQ-020 Same-cycle write commit and AR handshake to the same register: the read SHALL return the pre-write value.
REQ-021 len = 255 SHALL be handled without counter overflow, i.e. an 8-bit counter.
REQ-022 aw.burst, lock, cache, prot, qos, region, user, atop, and w.last SHALL be ignored. Beat counting SHALL rely on len only.
REQ-023 Outputs SHALL come from registers only, with no combinational path from req_i to resp_o.

Reset
REQ-024 While srst_i=1 at a clock edge:
- both FSMs go to IDLE;
- beat counters, latched ids, r.data and b/r resp become 0;
- all registers become 0.
REQ-025 During and in the first cycle after reset:
- aw_ready=1 and ar_ready=1;
- w_ready=0, b_valid=0, r_valid=0.
REQ-026 Reset mid-transaction (W_DATA, W_RESP or R_DATA) SHALL abandon the transaction, issue no B/R for it, and keep register writes already committed by earlier W handshakes zeroed by REQ-024.

Verification
REQ-027 Write then read, default parameters:
- AW 'h40000000, W 'hFEDCBA9876543210 strb 'hFF, then AR 'h40000000.
- Required: B OKAY id 0; R data 'hFEDCBA9876543210, OKAY, last=1.
REQ-028 Strobe merge on the same register:
- Write 'hFFFFFFFFFFFFFFFF strb 'b10100011, then 'hFFFFFFFFFFFFFFFF strb 'b01011100, then 'h0 strb 'b01010101.
- Required: read returns 'hFF00FF00FF00FF00.
REQ-029 Error decode:
- AR 'h40000040 -> R DECERR, data 0.
- AR 'h40000004 -> SLVERR.
- AW 'h40000008 len 3 with 4 W beats -> single B SLVERR; register 1 unchanged.
REQ-030 Backpressure:
- Hold b_ready=0 for 5 cycles -> b_valid stays 1, aw_ready stays 0.
- Hold r_ready=0 on AR len 2 -> beats held, then delivered as 3 beats with last only on the 3rd.
REQ-031 Concurrency:
- AR handshake on the same edge as a W commit to register 2 (old 'h11, new 'h22) -> R returns 'h11.
- A following read returns 'h22.
REQ-032 Reset mid-burst:
- Assert srst_i for one cycle while in R_DATA on beat 1 of 3.
- Required: r_valid=0 next cycle, ar_ready=1, all registers read back 0.

Source files
------------

// File: rtl/axi_reg_responder_if.sv
// AXI4 request/response struct types and a bus interface that bundles them for the register responder.
// The interface carries one request struct (initiator to target) and one response struct (target to initiator).
package soc_pkg;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic              user;
    } aw_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic              user;
    } ar_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
        logic              user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
        logic            user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic              user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } s_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } s_resp_t;
endpackage

interface axi_reg_responder_if #(
    parameter type req_t  = soc_pkg::s_req_t,
    parameter type resp_t = soc_pkg::s_resp_t
);
    req_t  req;
    resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/axi_reg_responder.sv
// AXI4 slave exposing NUM_REGS 64-bit registers with independent write and read state machines.
// Only single-beat, 64-bit, aligned accesses hit a register; everything else answers with an error code.
module axi_reg_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h4000_0000,
    parameter int unsigned NUM_REGS  = 8,
    parameter type         req_t     = soc_pkg::s_req_t,
    parameter type         resp_t    = soc_pkg::s_resp_t
) (
    input  logic  clk_i,
    input  logic  srst_i,
    input  req_t  req_i,
    output resp_t resp_o
);
    // W_IDLE: accept AW | W_DATA: take len+1 beats | W_RESP: hold B | R_IDLE: accept AR | R_DATA: stream beats
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [63:0] LIMIT = BASE_ADDR + 64'(8 * NUM_REGS);

    function automatic logic [1:0] decode(input logic [soc_pkg::ADDR_W-1:0] addr,
                                          input logic [7:0] len, input logic [2:0] size);
        if (64'(addr) < BASE_ADDR || 64'(addr) >= LIMIT) return RESP_DECERR;
        if (addr[2:0] != 3'd0 || size != 3'd3 || len != 8'd0) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] reg_idx(input logic [soc_pkg::ADDR_W-1:0] addr);
        return IDX_W'((64'(addr) - BASE_ADDR) >> 3);
    endfunction

    logic [63:0] regs_q [NUM_REGS];

    logic [1:0]                 w_state_q, w_state_d;
    logic [7:0]                 w_cnt_q,   w_cnt_d;
    logic [soc_pkg::ID_W-1:0]   w_id_q,    w_id_d;
    logic [IDX_W-1:0]           w_idx_q,   w_idx_d;
    logic [1:0]                 w_resp_q,  w_resp_d;
    logic                       w_commit;

    logic [0:0]                 r_state_q, r_state_d;
    logic [7:0]                 r_cnt_q,   r_cnt_d;
    logic [soc_pkg::ID_W-1:0]   r_id_q,    r_id_d;
    logic [1:0]                 r_resp_q,  r_resp_d;
    logic [63:0]                r_data_q,  r_data_d;
    logic [1:0]                 ar_resp;

    // Burst type, cache attributes, w.last and friends carry no meaning here.
    logic unused_req;
    assign unused_req = ^req_i;

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_resp_d  = w_resp_q;
        w_commit  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (req_i.aw_valid) begin
                    w_state_d = W_DATA;
                    w_cnt_d   = req_i.aw.len;
                    w_id_d    = req_i.aw.id;
                    w_idx_d   = reg_idx(req_i.aw.addr);
                    w_resp_d  = decode(req_i.aw.addr, req_i.aw.len, req_i.aw.size);
                end
            end
            W_DATA: begin
                if (req_i.w_valid) begin
                    w_commit = (w_resp_q == RESP_OKAY);
                    if (w_cnt_q == 8'd0) w_state_d = W_RESP;
                    else                 w_cnt_d   = w_cnt_q - 8'd1;
                end
            end
            W_RESP: begin
                if (req_i.b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_resp_q  <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_resp_q  <= w_resp_d;
            if (w_commit) begin
                for (int k = 0; k < 8; k++) begin
                    if (req_i.w.strb[k]) regs_q[w_idx_q][8*k +: 8] <= req_i.w.data[8*k +: 8];
                end
            end
        end
    end

    // The snapshot reads regs_q before any same-edge commit lands, so a racing read sees the old value.
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_id_d    = r_id_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;
        ar_resp   = decode(req_i.ar.addr, req_i.ar.len, req_i.ar.size);
        if (r_state_q == R_IDLE) begin
            if (req_i.ar_valid) begin
                r_state_d = R_DATA;
                r_cnt_d   = req_i.ar.len;
                r_id_d    = req_i.ar.id;
                r_resp_d  = ar_resp;
                r_data_d  = (ar_resp == RESP_OKAY) ? regs_q[reg_idx(req_i.ar.addr)] : 64'd0;
            end
        end else begin
            if (req_i.r_ready) begin
                if (r_cnt_q == 8'd0) r_state_d = R_IDLE;
                else                 r_cnt_d   = r_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_id_q    <= '0;
            r_resp_q  <= '0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_id_q    <= r_id_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
        end
    end

    always_comb begin
        resp_o          = '0;
        resp_o.aw_ready = (w_state_q == W_IDLE) || srst_i;
        resp_o.w_ready  = (w_state_q == W_DATA) && !srst_i;
        resp_o.b_valid  = (w_state_q == W_RESP) && !srst_i;
        resp_o.b.id     = w_id_q;
        resp_o.b.resp   = w_resp_q;
        resp_o.ar_ready = (r_state_q == R_IDLE) || srst_i;
        resp_o.r_valid  = (r_state_q == R_DATA) && !srst_i;
        resp_o.r.id     = r_id_q;
        resp_o.r.data   = r_data_q;
        resp_o.r.resp   = r_resp_q;
        resp_o.r.last   = (r_cnt_q == 8'd0);
    end
endmodule

// File: tb/tb_axi_reg_responder.sv
// Scoreboard bench for axi_reg_responder: drivers queue expected B/R responses, a negedge monitor checks them.
module tb_axi_reg_responder;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam int         LIMIT  = 200;

    logic clk  = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    axi_reg_responder_if bus ();

    axi_reg_responder #(
        .BASE_ADDR (64'h4000_0000),
        .NUM_REGS  (8)
    ) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .req_i  (bus.req),
        .resp_o (bus.resp)
    );

    typedef struct { logic [3:0] id; logic [1:0] resp; } exp_b_t;
    typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } exp_r_t;
    typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;

    exp_b_t exp_b [$];
    exp_r_t exp_r [$];
    chk_t   chk_q [$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endfunction

    // Monitor: the only process that counts comparisons.
    always @(negedge clk) begin
        chk_t   c;
        exp_b_t eb;
        exp_r_t er;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, c.act, c.exp);
        end
        if (!srst && bus.resp.b_valid && bus.req.b_ready) begin
            if (exp_b.size() == 0) cmp("b_unexpected", 64'(bus.resp.b_valid), 64'd0);
            else begin
                eb = exp_b.pop_front();
                cmp("b_id",   64'(bus.resp.b.id),   64'(eb.id));
                cmp("b_resp", 64'(bus.resp.b.resp), 64'(eb.resp));
            end
        end
        if (!srst && bus.resp.r_valid && bus.req.r_ready) begin
            if (exp_r.size() == 0) cmp("r_unexpected", 64'(bus.resp.r_valid), 64'd0);
            else begin
                er = exp_r.pop_front();
                cmp("r_id",   64'(bus.resp.r.id),   64'(er.id));
                cmp("r_data", bus.resp.r.data,      er.data);
                cmp("r_resp", 64'(bus.resp.r.resp), 64'(er.resp));
                cmp("r_last", 64'(bus.resp.r.last), 64'(er.last));
            end
        end
    end

    task automatic expect_now(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
        int n = 0;
        bus.req.aw       = '0;
        bus.req.aw.id    = id;
        bus.req.aw.addr  = addr;
        bus.req.aw.len   = len;
        bus.req.aw.size  = size;
        bus.req.aw.burst = 2'b01;
        bus.req.aw_valid = 1'b1;
        @(negedge clk);
        while (!bus.resp.aw_ready && n < LIMIT) begin n++; @(negedge clk); end
        if (n >= LIMIT) expect_now("aw_timeout", 64'(bus.resp.aw_ready), 64'd1);
        @(posedge clk); #1;
        bus.req.aw_valid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        bus.req.w.data  = data;
        bus.req.w.strb  = strb;
        bus.req.w.last  = last;
        bus.req.w_valid = 1'b1;
        @(negedge clk);
        while (!bus.resp.w_ready && n < LIMIT) begin n++; @(negedge clk); end
        if (n >= LIMIT) expect_now("w_timeout", 64'(bus.resp.w_ready), 64'd1);
        @(posedge clk); #1;
        bus.req.w_valid = 1'b0;
    endtask

    task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
        int n = 0;
        bus.req.ar       = '0;
        bus.req.ar.id    = id;
        bus.req.ar.addr  = addr;
        bus.req.ar.len   = len;
        bus.req.ar.size  = size;
        bus.req.ar.burst = 2'b01;
        bus.req.ar_valid = 1'b1;
        @(negedge clk);
        while (!bus.resp.ar_ready && n < LIMIT) begin n++; @(negedge clk); end
        if (n >= LIMIT) expect_now("ar_timeout", 64'(bus.resp.ar_ready), 64'd1);
        @(posedge clk); #1;
        bus.req.ar_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [63:0] data, input logic [7:0] strb, input logic [1:0] resp);
        exp_b_t eb;
        eb.id   = id;
        eb.resp = resp;
        exp_b.push_back(eb);
        aw_hs(id, addr, len, 3'd3);
        for (int i = 0; i <= int'(len); i++) w_beat(data, strb, i == int'(len));
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [63:0] data, input logic [1:0] resp);
        exp_r_t er;
        for (int i = 0; i <= int'(len); i++) begin
            er.id   = id;
            er.data = data;
            er.resp = resp;
            er.last = (i == int'(len));
            exp_r.push_back(er);
        end
        ar_hs(id, addr, len, size);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(bus.resp.aw_ready && bus.resp.ar_ready) && n < LIMIT) begin n++; @(negedge clk); end
        if (n >= LIMIT) expect_now("idle_timeout", 64'(bus.resp.ar_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        expect_now({tag, "_aw_ready"}, 64'(bus.resp.aw_ready), 64'd1);
        expect_now({tag, "_ar_ready"}, 64'(bus.resp.ar_ready), 64'd1);
        expect_now({tag, "_w_ready"},  64'(bus.resp.w_ready),  64'd0);
        expect_now({tag, "_b_valid"},  64'(bus.resp.b_valid),  64'd0);
        expect_now({tag, "_r_valid"},  64'(bus.resp.r_valid),  64'd0);
    endtask

    initial begin
        exp_b_t eb;
        exp_r_t er;
        int     n;
        bus.req         = '0;
        bus.req.b_ready = 1'b1;
        bus.req.r_ready = 1'b1;
        srst            = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("in_reset");
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");
        expect_now("after_reset_b_resp", 64'(bus.resp.b.resp), 64'd0);
        @(posedge clk); #1;

        // Basic write then read.
        wr(4'd0, 32'h4000_0000, 8'd0, 64'hFEDC_BA98_7654_3210, 8'hFF, OKAY);
        rd(4'd0, 32'h4000_0000, 8'd0, 3'd3, 64'hFEDC_BA98_7654_3210, OKAY);

        // Strobe merge on register 3.
        wr(4'd1, 32'h4000_0018, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'b1010_0011, OKAY);
        wr(4'd1, 32'h4000_0018, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'b0101_1100, OKAY);
        wr(4'd1, 32'h4000_0018, 8'd0, 64'h0,                   8'b0101_0101, OKAY);
        rd(4'd2, 32'h4000_0018, 8'd0, 3'd3, 64'hFF00_FF00_FF00_FF00, OKAY);

        // Address decode boundaries and error codes.
        rd(4'd3, 32'h4000_0040, 8'd0, 3'd3, 64'd0, DECERR);
        rd(4'd4, 32'h4000_0004, 8'd0, 3'd3, 64'd0, SLVERR);
        rd(4'd4, 32'h3FFF_FFF8, 8'd0, 3'd3, 64'd0, DECERR);
        rd(4'd5, 32'h4000_0038, 8'd0, 3'd3, 64'd0, OKAY);
        rd(4'd5, 32'h4000_0008, 8'd0, 3'd2, 64'd0, SLVERR);
        wr(4'd2, 32'h4000_0008, 8'd0, 64'h1111_2222_3333_4444, 8'hFF, OKAY);
        wr(4'd3, 32'h4000_0008, 8'd3, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, SLVERR);
        rd(4'd6, 32'h4000_0008, 8'd0, 3'd3, 64'h1111_2222_3333_4444, OKAY);

        // B backpressure.
        wait_idle();
        bus.req.b_ready = 1'b0;
        wr(4'd4, 32'h4000_0020, 8'd0, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, OKAY);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_now("bp_b_valid",  64'(bus.resp.b_valid),  64'd1);
            expect_now("bp_aw_ready", 64'(bus.resp.aw_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.req.b_ready = 1'b1;

        // R backpressure on a three-beat (errored) burst.
        wait_idle();
        bus.req.r_ready = 1'b0;
        rd(4'd7, 32'h4000_0028, 8'd2, 3'd3, 64'd0, SLVERR);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expect_now("bp_r_valid",  64'(bus.resp.r_valid),  64'd1);
            expect_now("bp_r_last",   64'(bus.resp.r.last),   64'd0);
            expect_now("bp_ar_ready", 64'(bus.resp.ar_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.req.r_ready = 1'b1;

        // AR on the same edge as a W commit to register 2.
        wr(4'd7, 32'h4000_0010, 8'd0, 64'h11, 8'hFF, OKAY);
        wait_idle();
        eb.id   = 4'd8;
        eb.resp = OKAY;
        exp_b.push_back(eb);
        aw_hs(4'd8, 32'h4000_0010, 8'd0, 3'd3);
        er.id   = 4'd9;
        er.data = 64'h11;
        er.resp = OKAY;
        er.last = 1'b1;
        exp_r.push_back(er);
        fork
            w_beat(64'h22, 8'hFF, 1'b1);
            ar_hs(4'd9, 32'h4000_0010, 8'd0, 3'd3);
        join
        rd(4'd10, 32'h4000_0010, 8'd0, 3'd3, 64'h22, OKAY);

        // Reset while on beat 1 of a three-beat read.
        wait_idle();
        er.id   = 4'd11;
        er.data = 64'd0;
        er.resp = SLVERR;
        er.last = 1'b0;
        exp_r.push_back(er);
        ar_hs(4'd11, 32'h4000_0010, 8'd2, 3'd3);
        @(posedge clk); #1;
        bus.req.r_ready = 1'b0;
        srst            = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        expect_now("rst_mid_r_valid",  64'(bus.resp.r_valid),  64'd0);
        expect_now("rst_mid_ar_ready", 64'(bus.resp.ar_ready), 64'd1);
        expect_now("rst_mid_aw_ready", 64'(bus.resp.aw_ready), 64'd1);
        @(posedge clk); #1;
        bus.req.r_ready = 1'b1;
        for (int i = 0; i < 8; i++) rd(4'd12, 32'h4000_0000 + 32'(8 * i), 8'd0, 3'd3, 64'd0, OKAY);

        n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 500) begin n++; @(negedge clk); end
        expect_now("b_queue_drained", 64'(exp_b.size()), 64'd0);
        expect_now("r_queue_drained", 64'(exp_r.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
